// File: rtl/fuzz_stim_pkg.sv
// ============================================================================
// fuzz_stim_pkg : shared types and LCG constants for the stimulus sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package fuzz_stim_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LCG_A = 32'h41C64E6D;
  localparam logic [31:0] LCG_C = 32'h00003039;

  // Jump-ahead pair {A_j, C_j} so that step_j(x) = A_j*x + C_j (mod 2^32).
  function automatic logic [63:0] lcg_jump_pair(input int j);
    logic [31:0] a;
    logic [31:0] c;
    a = 32'd1;
    c = 32'd0;
    for (int i = 0; i < j; i++) begin
      a = a * LCG_A;
      c = c * LCG_A + LCG_C;
    end
    return {a, c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fuzz_stim_sequencer_lcg_jump.sv
// ============================================================================
// lcg_jump : single combinational affine LCG step y = A*x + C (mod 2^32)
// Revision 1.0
// ============================================================================
`default_nettype none

module lcg_jump
  import fuzz_stim_pkg::*;
#(
  parameter logic [31:0] A = LCG_A,
  parameter logic [31:0] C = LCG_C
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = A * x + C;

endmodule

`default_nettype wire

// File: rtl/fuzz_stim_sequencer.sv
// ============================================================================
// fuzz_stim_sequencer : clocked LCG stimulus generator with DUT reset control
// Revision 1.0
// ============================================================================
`default_nettype none

module fuzz_stim_sequencer
  import fuzz_stim_pkg::*;
#(
  parameter int          IN_W       = 137,
  parameter int          RST_CYCLES = 2,
  parameter logic [31:0] DEF_SEED   = 32'd240029841
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     seed_i,
  input  logic [31:0]     cycles_i,
  input  logic            hold,
  output logic [IN_W-1:0] stim,
  output logic            stim_valid,
  output logic            dut_rst_n,
  output logic            busy,
  output logic            done,
  output logic [31:0]     cyc_count
);

  localparam int          c_NWORDS   = (IN_W + 31) / 32;
  localparam logic [31:0] c_RST_LAST = 32'(RST_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]            r_lcg;
  logic [31:0]            r_target;
  logic [31:0]            r_rst_cnt;
  logic [32*c_NWORDS-1:0] w_words;
  logic [31:0]            w_seed_eff;
  logic [31:0]            w_lcg_src;
  logic [IN_W-1:0]        w_stim_nxt;
  logic [31:0]            w_lcg_nxt;
  logic [31:0]            w_target_nxt;
  logic [31:0]            w_rst_cnt_nxt;
  logic [31:0]            w_count_nxt;

  assign w_seed_eff = (seed_i == 32'd0) ? DEF_SEED : seed_i;
  // In IDLE the next vector is vector 0 of a fresh run, built from the seed.
  assign w_lcg_src  = (r_state == S_IDLE) ? w_seed_eff : r_lcg;

  generate
    for (genvar k = 0; k < c_NWORDS; k++) begin : g_word
      localparam logic [63:0] c_PAIR = lcg_jump_pair(k + 1);
      lcg_jump #(
        .A (c_PAIR[63:32]),
        .C (c_PAIR[31:0])
      ) u_jump (
        .x (w_lcg_src),
        .y (w_words[32*k +: 32])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt   = r_state;
    w_stim_nxt    = stim;
    w_lcg_nxt     = r_lcg;
    w_target_nxt  = r_target;
    w_rst_cnt_nxt = r_rst_cnt;
    w_count_nxt   = cyc_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_RST;
          w_stim_nxt    = w_words[IN_W-1:0];
          w_lcg_nxt     = w_words[32*(c_NWORDS-1) +: 32];
          w_target_nxt  = cycles_i;
          w_rst_cnt_nxt = 32'd0;
          w_count_nxt   = 32'd0;
        end
      end
      S_RST: begin
        if (r_rst_cnt == c_RST_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 32'd1;
        end
      end
      S_RUN: begin
        // Completion wins over hold, and the count can never pass the target.
        if (cyc_count == r_target) begin
          w_state_nxt = S_DONE;
        end else if (!hold) begin
          w_stim_nxt  = w_words[IN_W-1:0];
          w_lcg_nxt   = w_words[32*(c_NWORDS-1) +: 32];
          w_count_nxt = cyc_count + 32'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lcg      <= 32'd0;
      r_target   <= 32'd0;
      r_rst_cnt  <= 32'd0;
      stim       <= '0;
      cyc_count  <= 32'd0;
      stim_valid <= 1'b0;
      dut_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lcg      <= w_lcg_nxt;
      r_target   <= w_target_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      stim       <= w_stim_nxt;
      cyc_count  <= w_count_nxt;
      stim_valid <= (w_state_nxt == S_RST) || (w_state_nxt == S_RUN);
      busy       <= (w_state_nxt == S_RST) || (w_state_nxt == S_RUN);
      dut_rst_n  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      done       <= (w_state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fuzz_stim_sequencer.sv
// ============================================================================
// tb_fuzz_stim_sequencer : table-driven and randomized check of the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fuzz_stim_sequencer;

  localparam int          IN_W       = 137;
  localparam int          RST_CYCLES = 2;
  localparam logic [31:0] DEF_SEED   = 32'd240029841;
  localparam int          NW         = 5;

  logic            clk;
  logic            rst;
  logic            start;
  logic [31:0]     seed_i;
  logic [31:0]     cycles_i;
  logic            hold;
  logic [IN_W-1:0] stim;
  logic            stim_valid;
  logic            dut_rst_n;
  logic            busy;
  logic            done;
  logic [31:0]     cyc_count;
  logic [IN_W-1:0] z_stim;
  logic            z_stim_valid;
  logic            z_dut_rst_n;
  logic            z_busy;
  logic            z_done;
  logic [31:0]     z_cyc_count;

  int n_vec = 0;
  int n_err = 0;

  fuzz_stim_sequencer #(
    .IN_W(IN_W), .RST_CYCLES(RST_CYCLES), .DEF_SEED(DEF_SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed_i(seed_i), .cycles_i(cycles_i),
    .hold(hold), .stim(stim), .stim_valid(stim_valid), .dut_rst_n(dut_rst_n),
    .busy(busy), .done(done), .cyc_count(cyc_count)
  );

  // Same block with a zero default seed, so an all-zero LCG state is reachable.
  fuzz_stim_sequencer #(
    .IN_W(IN_W), .RST_CYCLES(RST_CYCLES), .DEF_SEED(32'd0)
  ) dut_z (
    .clk(clk), .rst(rst), .start(start), .seed_i(seed_i), .cycles_i(cycles_i),
    .hold(hold), .stim(z_stim), .stim_valid(z_stim_valid), .dut_rst_n(z_dut_rst_n),
    .busy(z_busy), .done(z_done), .cyc_count(z_cyc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] seed;
    logic [31:0] cycles;
    int          hold_mode;
    int          hold_at;
    bit          poke;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h00003039;
  endfunction

  // One vector = NW sequential LCG steps packed low word first, truncated to IN_W.
  function automatic void model_vec(input logic [31:0] xin, output logic [IN_W-1:0] v,
                                    output logic [31:0] xout);
    logic [31:0] s;
    s = xin;
    v = '0;
    for (int w = 0; w < NW; w++) begin
      s = lcg(s);
      for (int b = 0; b < 32; b++) begin
        if (w * 32 + b < IN_W) v[w*32+b] = s[b];
      end
    end
    xout = s;
  endfunction

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic poke_start();
    start    = 1'($urandom_range(0, 1));
    seed_i   = $urandom;
    cycles_i = $urandom;
  endtask

  task automatic run_check(input logic [31:0] seed, input logic [31:0] cyc, input int hold_mode,
                           input int hold_at, input bit poke, input logic [31:0] exp_w0);
    logic [31:0]     x;
    logic [31:0]     y;
    logic [IN_W-1:0] v;
    int              k;
    int              lat;
    int              holds;
    int              iter;
    bit              h;
    bit              fin;
    x = (seed == 32'd0) ? DEF_SEED : seed;
    y = x;
    repeat (NW) y = lcg(y);
    @(negedge clk);
    start = 1'b1; seed_i = seed; cycles_i = cyc; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    model_vec(x, v, x);
    chk32("word0", stim[31:0], exp_w0);
    chkv("vec0", stim, v);
    chk32("word4_low9", {23'd0, stim[136:128]}, {23'd0, y[8:0]});
    chk32("rst_valid", {31'd0, stim_valid}, 32'd1);
    chk32("rst_dut_rst_n", {31'd0, dut_rst_n}, 32'd0);
    chk32("rst_busy", {31'd0, busy}, 32'd1);
    chk32("rst_count", cyc_count, 32'd0);
    if (seed == 32'd0) begin
      chk32("zseed_w0", z_stim[31:0], 32'h00003039);
      chk32("zseed_w1", z_stim[63:32], 32'hD3DC167E);
    end
    for (int i = 1; i < RST_CYCLES; i++) begin
      if (poke) poke_start();
      @(negedge clk);
      lat++;
      chk32("rst_hold_n", {31'd0, dut_rst_n}, 32'd0);
      chkv("rst_stim", stim, v);
    end
    if (poke) poke_start();
    @(negedge clk);
    lat++;
    k = 0; holds = 0; iter = 0; h = 1'b0; fin = 1'b0;
    while (!fin) begin
      chk32("run_dut_rst_n", {31'd0, dut_rst_n}, 32'd1);
      chk32("run_valid", {31'd0, stim_valid}, 32'd1);
      chk32("run_done", {31'd0, done}, 32'd0);
      chk32("run_count", cyc_count, 32'(k));
      chkv("run_stim", stim, v);
      if (32'(k) == cyc) begin
        hold = 1'($urandom_range(0, 1));
        fin  = 1'b1;
      end else begin
        h = (hold_mode == 1 && k == hold_at && holds < 3) ||
            (hold_mode == 2 && iter < 4 * int'(cyc) + 8 && $urandom_range(0, 3) == 0);
        hold = h;
      end
      if (poke) poke_start();
      @(negedge clk);
      lat++;
      iter++;
      if (!fin) begin
        if (h) holds++;
        else begin
          model_vec(x, v, x);
          k++;
        end
      end
    end
    hold = 1'b0;
    start = 1'b0;
    chk32("done_pulse", {31'd0, done}, 32'd1);
    chk32("done_busy", {31'd0, busy}, 32'd0);
    chk32("done_valid", {31'd0, stim_valid}, 32'd0);
    chk32("done_dut_rst_n", {31'd0, dut_rst_n}, 32'd1);
    chk32("done_count", cyc_count, cyc);
    chk32("latency", 32'(lat), 32'(RST_CYCLES) + cyc + 32'd2 + 32'(holds));
    @(negedge clk);
    chk32("done_once", {31'd0, done}, 32'd0);
    chk32("idle_busy", {31'd0, busy}, 32'd0);
    chk32("idle_dut_rst_n", {31'd0, dut_rst_n}, 32'd0);
    chk32("idle_count", cyc_count, cyc);
    chkv("idle_stim", stim, v);
  endtask

  initial begin
    logic [31:0] s;
    bit          found;
    tbl[0] = '{seed: 32'd1, cycles: 32'd0, hold_mode: 0, hold_at: 0, poke: 1'b0,
               exp_w0: 32'h41C67EA6};
    tbl[1] = '{seed: 32'd0, cycles: 32'd0, hold_mode: 0, hold_at: 0, poke: 1'b0,
               exp_w0: lcg(DEF_SEED)};
    tbl[2] = '{seed: 32'd240029841, cycles: 32'd200, hold_mode: 0, hold_at: 0, poke: 1'b0,
               exp_w0: lcg(32'd240029841)};
    tbl[3] = '{seed: 32'd7, cycles: 32'd8, hold_mode: 1, hold_at: 4, poke: 1'b0,
               exp_w0: lcg(32'd7)};
    tbl[4] = '{seed: 32'hDEADBEEF, cycles: 32'd12, hold_mode: 0, hold_at: 0, poke: 1'b1,
               exp_w0: lcg(32'hDEADBEEF)};
    tbl[5] = '{seed: 32'hFFFFFFFF, cycles: 32'd20, hold_mode: 2, hold_at: 0, poke: 1'b1,
               exp_w0: lcg(32'hFFFFFFFF)};

    rst = 1'b1; start = 1'b0; seed_i = 32'd0; cycles_i = 32'd0; hold = 1'b0;
    #3;
    chkv("reset_stim", stim, '0);
    chk32("reset_flags", {27'd0, stim_valid, dut_rst_n, busy, done, 1'b0}, 32'd0);
    chk32("reset_count", cyc_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_check(tbl[i].seed, tbl[i].cycles, tbl[i].hold_mode, tbl[i].hold_at,
                tbl[i].poke, tbl[i].exp_w0);
    end

    // Asynchronous reset part-way through a run, then a clean restart.
    @(negedge clk);
    start = 1'b1; seed_i = 32'h00001234; cycles_i = 32'd50;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cyc_count == 32'd10) found = 1'b1;
    end
    chk32("reach_count10", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chkv("midrst_stim", stim, '0);
    chk32("midrst_flags", {27'd0, stim_valid, dut_rst_n, busy, done, 1'b0}, 32'd0);
    chk32("midrst_count", cyc_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_check(32'h00001234, 32'd3, 0, 0, 1'b0, lcg(32'h00001234));

    for (int r = 0; r < 6; r++) begin
      s = $urandom;
      run_check(s, 32'($urandom_range(0, 30)), 2, 0, bit'($urandom_range(0, 1)), lcg(s == 0 ? DEF_SEED : s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fuzz_stim_sequencer.md
# fuzz_stim_sequencer

Synthesizable stimulus sequencer for the rewiring fuzz harness. It replaces the behavioural LCG stimulus loop around a fuzzed `top` with a clocked block. The block holds the DUT in reset, then generates one pseudo-random `in_flat` vector per clock from a 32-bit LCG seed, counts vectors and signals completion. It sits between a run controller (seed/cycle count/start) and the DUT's `rst_n`/`in_flat` ports, so fuzz runs can execute on emulation/FPGA with bit-identical stimulus.

## Interface
- `IN_W`, 137: DUT `in_flat` width; number of LCG words per vector `NWORDS = ceil(IN_W/32)` (5 at default).
- `RST_CYCLES`, 2: cycles `dut_rst_n` is held low before stimulus runs (≥1).
- `DEF_SEED`, 240029841: seed used when `seed_i == 0`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `seed_i`  in  32  LCG seed, latched on `start`.
- `cycles_i`  in  32  number of vectors after the initial one, latched on `start`.
- `hold`  in  1  freeze stimulus in RUN (no advance, no count).
- `stim`  out  IN_W  vector to DUT `in_flat`.
- `stim_valid`  out  1  `stim` is part of the active run.
- `dut_rst_n`  out  1  active-low reset to DUT.
- `busy`  out  1  run in progress (RST or RUN).
- `done`  out  1  one-cycle completion pulse.
- `cyc_count`  out  32  vectors advanced in current/last run.

## Operation
- LCG: `x' = x*32'h41C64E6D + 32'h3039` mod 2^32.
- Word k (0-based) of a vector is LCG step k+1 from state `x`.
  - Word k maps to `stim[32k+31:32k]`.
  - The last word is truncated to its low `IN_W - 32*(NWORDS-1)` bits.
  - After a vector is formed, `x` is set to step NWORDS.
- All NWORDS words are computed in one cycle using jump-ahead constants: `step_j(x) = A_j*x + C_j` mod 2^32, with `A_1 = 32'h41C64E6D`, `C_1 = 32'h3039`.
- States:
  - **IDLE**: `busy=0`, `stim_valid=0`, `dut_rst_n=0`, `stim` holds its last value.
    - On `start`: latch seed (`DEF_SEED` if `seed_i == 0`) and `cycles_i`; clear `cyc_count`; load vector 0 into `stim`; go to RST.
  - **RST**: `dut_rst_n=0`, `busy=1`, `stim_valid=1`; stay `RST_CYCLES` cycles, then go to RUN.
  - **RUN**: `dut_rst_n=1`, `busy=1`, `stim_valid=1`.
    - If `cyc_count == target`: go to DONE. This check has priority over `hold`.
    - Else if `!hold`: load the next vector and increment `cyc_count`.
    - Else: hold everything.
  - **DONE**: one cycle, `done=1`, `busy=0`, `stim_valid=0`, `dut_rst_n=1`; then IDLE.
- `start` outside IDLE is ignored. There is no abort; `rst` is the only abort.
- `cycles_i = 0`: RST → RUN for one cycle → DONE, with `cyc_count = 0`.
- `cyc_count` saturates at the 32-bit target, so it never wraps.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE;
  - `stim = 0`, `stim_valid = 0`, `dut_rst_n = 0`, `busy = 0`, `done = 0`, `cyc_count = 0`;
  - LCG state = 0.
- Reset mid-run returns the block to IDLE with the values above. The DUT is re-held in reset.
- `start` high at edge T:
  - T+1: `stim` = vector 0, `stim_valid = 1`, `dut_rst_n = 0`.
  - T+1+RST_CYCLES: `dut_rst_n = 1`.
  - From the next edge, one vector per non-hold cycle.
- Latency from `start` to `done` with no hold: `RST_CYCLES + cycles + 2` cycles.
- Every output is registered; no combinational path from input to output.

## Structure
- Package `fuzz_stim_pkg`: the state enum; `LCG_A`, `LCG_C`; a constant function that computes the jump-ahead pairs `(A_j, C_j)` for j = 1..NWORDS.
- Sub-module `lcg_jump`: one combinational `A*x + C` with 32-bit wrap. Instantiate it NWORDS times through a generate block.

## Test plan
- `seed_i = 32'd1`, `cycles_i = 0`, `start` → `stim[31:0] = 32'h41C67EA6` at T+1; `done` at T+RST_CYCLES+2; `cyc_count = 0`.
- `seed_i = 32'd0`, `cycles_i = 0` → the default seed is used. Separately force seed 0 by setting `DEF_SEED = 0` and check `stim[31:0] = 32'h00003039`, `stim[63:32] = 32'hD3DC167E`.
- `seed_i = 240029841`, `cycles_i = 200` → compare every vector against a reference LCG model. Check `stim[136:128]` = low 9 bits of word 4, `cyc_count = 200`, and `done` exactly once.
- `hold` high for 3 cycles mid-RUN → `stim` and `cyc_count` unchanged during hold; completion delayed by exactly 3 cycles.
- `rst` pulse during RUN at `cyc_count = 10` → all outputs at reset values immediately. A restart with the same seed reproduces vector 0.
- `start` pulsed during RST and RUN → ignored; `target`, seed and the vector sequence are unchanged.
